// File: rtl/piksel_besleyici.sv
// piksel_besleyici: streams one frame from frame RAM into a 2-entry FIFO
// Optional checksum on toplam_o enabled by macro PIKSEL_BESLEYICI_TOPLAM_EN
module piksel_besleyici #(
    parameter int PIKSEL_SAYISI = 76800,
    parameter int ADR_W         = 17,
    parameter int VERI_W        = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    output logic              ram_en_o,
    output logic [ADR_W-1:0]  ram_adr_o,
    input  logic [VERI_W-1:0] ram_veri_i,
    output logic [VERI_W-1:0] veri_o,
    output logic              veri_gecerli_o,
    input  logic              veri_al_i,
    output logic              bitti_o,
    output logic [ADR_W-1:0]  sayac_o,
    output logic [15:0]       toplam_o
);

    typedef enum logic [1:0] {BOSTA, OKU, BOSALT, BITTI} durum_t;

    localparam logic [ADR_W-1:0] SON = ADR_W'(PIKSEL_SAYISI - 1);

    durum_t            durum;
    logic [ADR_W-1:0]  okuma_adr;
    logic              ucta;
    logic [VERI_W-1:0] yedek;
    logic              yedek_v;
    logic              al;
    logic              oku;
    logic              basla;
    logic [1:0]        kredi;

    // Read credit: buffered + in-flight, with this cycle's pop freeing a slot
    always_comb begin
        al    = veri_gecerli_o & veri_al_i;
        basla = (durum == BOSTA) & en_i;
        kredi = 2'(veri_gecerli_o) + 2'(yedek_v) + 2'(ucta);
        oku   = (durum == OKU) && (kredi < (2'd2 + 2'(al)));
    end

    assign ram_en_o  = oku;
    assign ram_adr_o = okuma_adr;

    // Frame sequencing, read address generation and transfer counting
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            durum     <= BOSTA;
            okuma_adr <= '0;
            ucta      <= 1'b0;
            sayac_o   <= '0;
            bitti_o   <= 1'b0;
        end else begin
            ucta <= oku;
            if (al) sayac_o <= sayac_o + 1'b1;
            case (durum)
                BOSTA: begin
                    if (en_i) begin
                        durum     <= OKU;
                        okuma_adr <= '0;
                        sayac_o   <= '0;
                    end
                end
                OKU: begin
                    if (oku) begin
                        if (okuma_adr == SON) durum <= BOSALT;
                        else okuma_adr <= okuma_adr + 1'b1;
                    end
                end
                BOSALT: begin
                    if (al && sayac_o == SON) begin
                        durum   <= BITTI;
                        bitti_o <= 1'b1;
                    end
                end
                BITTI: begin
                    if (!en_i) begin
                        durum   <= BOSTA;
                        bitti_o <= 1'b0;
                    end
                end
                default: durum <= BOSTA;
            endcase
        end
    end

    // Two-entry FIFO whose head register drives veri_o directly
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            veri_o         <= '0;
            veri_gecerli_o <= 1'b0;
            yedek          <= '0;
            yedek_v        <= 1'b0;
        end else if (ucta && al) begin
            if (yedek_v) begin
                veri_o <= yedek;
                yedek  <= ram_veri_i;
            end else begin
                veri_o <= ram_veri_i;
            end
        end else if (al) begin
            if (yedek_v) begin
                veri_o  <= yedek;
                yedek_v <= 1'b0;
            end else begin
                veri_gecerli_o <= 1'b0;
            end
        end else if (ucta) begin
            if (!veri_gecerli_o) begin
                veri_o         <= ram_veri_i;
                veri_gecerli_o <= 1'b1;
            end else begin
                yedek   <= ram_veri_i;
                yedek_v <= 1'b1;
            end
        end
    end

`ifdef PIKSEL_BESLEYICI_TOPLAM_EN
    // Wrap-around sum of transferred pixels, restarted with each frame
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) toplam_o <= '0;
        else if (basla) toplam_o <= '0;
        else if (al) toplam_o <= toplam_o + 16'(veri_o);
    end
`else
    logic basla_kullanilmaz;
    assign basla_kullanilmaz = basla;
    assign toplam_o = '0;
`endif

endmodule

// File: doc/piksel_besleyici.md
PIKSEL_BESLEYICI -- requirements
Module: piksel_besleyici

Interface
REQ-001 The block SHALL have parameter PIKSEL_SAYISI, default 76800, number of pixels per frame (320x240).
REQ-002 The block SHALL have parameter ADR_W, default 17, RAM address width.
REQ-003 The block SHALL have parameter VERI_W, default 8, pixel width.
REQ-004 The block SHALL have port clk_i  input  1  single clock, all logic on rising edge.
REQ-005 The block SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have port en_i  input  1  frame start request, sampled only in state BOSTA.
REQ-007 The block SHALL have port ram_en_o  output  1  frame-RAM read enable (we tied low externally).
REQ-008 The block SHALL have port ram_adr_o  output  ADR_W  frame-RAM read address.
REQ-009 The block SHALL have port ram_veri_i  input  VERI_W  frame-RAM read data, valid 1 cycle after ram_en_o=1.
REQ-010 The block SHALL have port veri_o  output  VERI_W  pixel to processing stage.
REQ-011 The block SHALL have port veri_gecerli_o  output  1  veri_o holds a valid pixel.
REQ-012 The block SHALL have port veri_al_i  input  1  processing stage accepts pixel this cycle.
REQ-013 The block SHALL have port bitti_o  output  1  whole frame delivered.
REQ-014 The block SHALL have port sayac_o  output  ADR_W  pixels delivered so far in current frame.
REQ-015 The block SHALL have port toplam_o  output  16  pixel checksum (see Configuration).

Function
REQ-016 A transfer SHALL occur on a rising edge where veri_gecerli_o=1 and veri_al_i=1; sayac_o increments by 1 on each transfer.
REQ-017 The FSM SHALL have states BOSTA, OKU, BOSALT, BITTI; BOSTA->OKU when en_i=1; OKU->BOSALT after read of address PIKSEL_SAYISI-1 issued; BOSALT->BITTI on final transfer; BITTI->BOSTA when en_i=0.
REQ-018 Reads SHALL be issued at ascending addresses 0..PIKSEL_SAYISI-1, each exactly once, only while (buffered pixels + in-flight reads) < 2.
REQ-019 Returned RAM data SHALL enter a 2-entry FIFO; veri_o/veri_gecerli_o SHALL present the FIFO head, registered.
REQ-020 Latency: first pixel (address 0) SHALL appear with veri_gecerli_o=1 exactly 2 cycles after the edge sampling en_i=1 in BOSTA.
REQ-021 With veri_al_i held high, throughput SHALL be 1 pixel/cycle with no bubbles after the first pixel.
REQ-022 veri_o SHALL stay stable while veri_gecerli_o=1 and veri_al_i=0; no pixel dropped or duplicated under any veri_al_i pattern.
REQ-023 Simultaneous FIFO push and pop SHALL keep occupancy unchanged; push on full SHALL never occur (guaranteed by REQ-018).
REQ-024 bitti_o SHALL rise the cycle after the transfer making sayac_o=PIKSEL_SAYISI and stay high through BITTI; veri_gecerli_o=0 and ram_en_o=0 in BITTI.
REQ-025 en_i changes outside BOSTA/BITTI SHALL be ignored; a new frame needs en_i low then high.

Reset
REQ-026 On rst_i=1, immediately and independent of clk_i: state=BOSTA, ram_en_o=0, ram_adr_o=0, veri_o=0, veri_gecerli_o=0, bitti_o=0, sayac_o=0, toplam_o=0, FIFO empty, in-flight count 0.
REQ-027 Reset mid-frame SHALL abort the frame; data returned by the RAM on the edge after release SHALL be discarded.

Configuration
REQ-028 Macro PIKSEL_BESLEYICI_TOPLAM_EN defined: toplam_o SHALL be the 16-bit wrap-around sum of all pixels transferred in the current frame, cleared on BOSTA->OKU.
REQ-029 Macro undefined: toplam_o SHALL be constant 0 and no adder logic SHALL be synthesised; all other behaviour unchanged.

Verification (PIKSEL_SAYISI=16 unless noted, RAM[i]=i+1)
REQ-030 en_i pulse, veri_al_i=1 constant -> veri_o 1..16 on 16 consecutive cycles, first 2 cycles after en_i, bitti_o high next cycle, sayac_o=16.
REQ-031 veri_al_i toggling 1,0,0,1 repeat -> same sequence 1..16, veri_o stable during stalls, no ram_adr_o repeated.
REQ-032 veri_al_i=0 for 20 cycles after start -> exactly 2 reads issued (adr 0,1), veri_o=1 held, then all 16 delivered once released.
REQ-033 rst_i asserted after 5th transfer mid-clock -> outputs zero immediately; new en_i restarts from address 0, veri_o=1 first.
REQ-034 PIKSEL_BESLEYICI_TOPLAM_EN defined, RAM[i]=255, PIKSEL_SAYISI=300 -> toplam_o=76500 mod 65536=10964; undefined -> toplam_o=0.
REQ-035 PIKSEL_SAYISI=76800, veri_al_i=1 -> bitti_o rises cycle 76802 after en_i, sayac_o=76800, last veri_o=RAM[76799].
